// File: rtl/nios_segments_scan_ctrl.sv
// nios_segments_scan_ctrl: multiplexed 7-segment scan controller with an Avalon-MM control slave
// Ports: clk, reset_n (async, active-low); address/chipselect/write_n/writedata/readdata form the
// Avalon slave (CTRL, DIV, STATUS, FRAMES); value_in is the 8-nibble display value; seg/dig are the
// registered segment bus and digit enables; frame_done pulses for one cycle after the last digit slot.
module nios_segments_scan_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int DEFAULT_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1,
    parameter bit DIG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [31:0]           value_in,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] dig,
    output logic                  frame_done
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [111:0] SEG_LUT = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
    typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, DRIVE = 2'd2} state_t;
    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [15:0]             pre_q, pre_d, div_q, div_d, frames_q, frames_d, effdiv;
    logic [31:0]             shadow_q, shadow_d;
    logic                    en_q, en_d, lzb_q, lzb_d, fd_q, fd_d;
    logic [7:0]              dp_q, dp_d, dmask_q, dmask_d, seg_q, seg_d, seg_act;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d, dig_act;
    logic                    wr, tc, wrap, lz, on;
    logic [3:0]              nib;
    logic                    unused_ok;
    assign unused_ok = &{1'b0, writedata[31:24], writedata[7:2]};
    always_comb begin
        wr       = chipselect & ~write_n;
        en_d     = (wr && address == 2'd0) ? writedata[0] : en_q;
        lzb_d    = (wr && address == 2'd0) ? writedata[1] : lzb_q;
        dp_d     = (wr && address == 2'd0) ? writedata[15:8] : dp_q;
        dmask_d  = (wr && address == 2'd0) ? writedata[23:16] : dmask_q;
        div_d    = (wr && address == 2'd1) ? writedata[15:0] : div_q;
        effdiv   = (div_d == 16'd0) ? 16'd1 : div_d;
        // >= rather than == so a DIV shrink below the running count ends the slot at once
        tc       = pre_q >= effdiv - 16'd1;
        state_d  = state_q;
        idx_d    = idx_q;
        pre_d    = pre_q;
        shadow_d = shadow_q;
        wrap     = 1'b0;
        if (!en_d) begin
            state_d = IDLE;
            idx_d   = '0;
            pre_d   = '0;
        end else if (state_q == IDLE) begin
            state_d  = BLANK;
            shadow_d = value_in;
        end else if (state_q == BLANK) begin
            state_d = DRIVE;
        end else if (tc) begin
            state_d  = BLANK;
            pre_d    = '0;
            wrap     = idx_q == IW'(NUM_DIGITS - 1);
            idx_d    = wrap ? '0 : idx_q + 1'b1;
            shadow_d = wrap ? value_in : shadow_q;
        end else begin
            pre_d = pre_q + 16'd1;
        end
        frames_d = (wr && address == 2'd3) ? 16'd0 : wrap ? frames_q + 16'd1 : frames_q;
        fd_d     = wrap;
        // outputs are derived from next state so the output registers line up with state_q
        nib      = shadow_d[{idx_d, 2'b00} +: 4];
        lz       = lzb_d && idx_d != '0 && (shadow_d >> {idx_d, 2'b00}) == 32'd0;
        on       = state_d == DRIVE && dmask_d[idx_d] && (!lz || dp_d[idx_d]);
        seg_act  = on ? {dp_d[idx_d], lz ? 7'd0 : SEG_LUT[7*nib +: 7]} : 8'd0;
        dig_act  = on ? NUM_DIGITS'(1) << idx_d : '0;
        seg_d    = seg_act ^ {8{SEG_ACTIVE_LOW}};
        dig_d    = dig_act ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            pre_q    <= '0;
            shadow_q <= '0;
            en_q     <= 1'b0;
            lzb_q    <= 1'b0;
            dp_q     <= '0;
            dmask_q  <= '0;
            div_q    <= 16'(DEFAULT_DIV);
            frames_q <= '0;
            fd_q     <= 1'b0;
            seg_q    <= {8{SEG_ACTIVE_LOW}};
            dig_q    <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pre_q    <= pre_d;
            shadow_q <= shadow_d;
            en_q     <= en_d;
            lzb_q    <= lzb_d;
            dp_q     <= dp_d;
            dmask_q  <= dmask_d;
            div_q    <= div_d;
            frames_q <= frames_d;
            fd_q     <= fd_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
        end
    end
    assign readdata   = address == 2'd0 ? {8'd0, dmask_q, dp_q, 6'd0, lzb_q, en_q} :
                        address == 2'd1 ? {16'd0, div_q} :
                        address == 2'd2 ? {22'd0, state_q, 5'd0, 3'(idx_q)} :
                                          {16'd0, frames_q};
    assign seg        = seg_q;
    assign dig        = dig_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_nios_segments_scan_ctrl.sv
// tb_nios_segments_scan_ctrl: directed table-driven bench for the 7-segment scan controller
module tb_nios_segments_scan_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [31:0] value_in = 32'd0;
    logic [7:0]  seg;
    logic [7:0]  dig;
    logic        frame_done;
    int          n_chk = 0;
    int          n_fail = 0;
    int          k = 0;
    logic [31:0] r;
    typedef struct {
        int          grp;
        int          k;
        logic [7:0]  dig;
        logic [7:0]  seg;
        logic        fd;
        logic [31:0] status;
    } vec_t;
    vec_t vecs[19];
    nios_segments_scan_ctrl dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .value_in(value_in),
        .seg(seg), .dig(dig), .frame_done(frame_done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (k=%0d)", name, got, exp, k);
        end
    endtask
    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask
    // called at a negedge; the write is captured on the following posedge
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n = 1'b1;
        k++;
    endtask
    task automatic step_to(input int target);
        while (k < target) begin
            @(negedge clk);
            k++;
        end
    endtask
    task automatic run_grp(input int g);
        for (int i = 0; i < 19; i++) begin
            if (vecs[i].grp == g) begin
                step_to(vecs[i].k);
                chk($sformatf("g%0d dig k%0d", g, vecs[i].k), {24'd0, dig}, {24'd0, vecs[i].dig});
                chk($sformatf("g%0d seg k%0d", g, vecs[i].k), {24'd0, seg}, {24'd0, vecs[i].seg});
                chk($sformatf("g%0d fd k%0d", g, vecs[i].k), {31'd0, frame_done}, {31'd0, vecs[i].fd});
                rd(2'd2, r);
                chk($sformatf("g%0d status k%0d", g, vecs[i].k), r, vecs[i].status);
            end
        end
    endtask
    initial begin
        vecs = '{
            '{2,  0, 8'hFF, 8'hFF, 1'b0, 32'h100},
            '{2,  1, 8'hFE, 8'h80, 1'b0, 32'h200},
            '{2,  2, 8'hFE, 8'h80, 1'b0, 32'h200},
            '{2,  3, 8'hFF, 8'hFF, 1'b0, 32'h101},
            '{2,  4, 8'hFD, 8'hF8, 1'b0, 32'h201},
            '{2,  7, 8'hFB, 8'h82, 1'b0, 32'h202},
            '{2, 22, 8'h7F, 8'hF9, 1'b0, 32'h207},
            '{2, 23, 8'h7F, 8'hF9, 1'b0, 32'h207},
            '{2, 24, 8'hFF, 8'hFF, 1'b1, 32'h100},
            '{2, 25, 8'hFE, 8'h80, 1'b0, 32'h200},
            '{2, 48, 8'hFF, 8'hFF, 1'b1, 32'h100},
            '{2, 72, 8'hFF, 8'hFF, 1'b1, 32'h100},
            '{3,  0, 8'hFF, 8'hFF, 1'b0, 32'h100},
            '{3,  1, 8'hFE, 8'h12, 1'b0, 32'h200},
            '{3,  3, 8'hFD, 8'hC0, 1'b0, 32'h201},
            '{3,  5, 8'hFB, 8'h88, 1'b0, 32'h202},
            '{3,  7, 8'hFF, 8'hFF, 1'b0, 32'h203},
            '{3, 15, 8'hFF, 8'hFF, 1'b0, 32'h207},
            '{3, 16, 8'hFF, 8'hFF, 1'b1, 32'h100}
        };
        // reset state, checked while reset is held and after release
        #12;
        chk("rst seg", {24'd0, seg}, 32'hFF);
        chk("rst dig", {24'd0, dig}, 32'hFF);
        chk("rst fd", {31'd0, frame_done}, 32'd0);
        rd(2'd0, r); chk("rst CTRL", r, 32'd0);
        rd(2'd1, r); chk("rst DIV", r, 32'd50000);
        rd(2'd2, r); chk("rst STATUS", r, 32'd0);
        rd(2'd3, r); chk("rst FRAMES", r, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post-rst dig", {24'd0, dig}, 32'hFF);
        // basic scan, DIV=2
        value_in = 32'h12345678;
        wr(2'd1, 32'd2);
        rd(2'd1, r); chk("DIV rb", r, 32'd2);
        wr(2'd0, 32'h00FF0001);
        k = 0;
        rd(2'd0, r); chk("CTRL rb", r, 32'h00FF0001);
        run_grp(2);
        rd(2'd3, r); chk("FRAMES=3", r, 32'd3);
        // leading-zero blanking and decimal point, DIV=1
        wr(2'd0, 32'd0);
        value_in = 32'h00000A05;
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h00FF0103);
        k = 0;
        run_grp(3);
        // frame snapshot: mid-frame value change only shows next frame
        wr(2'd0, 32'd0);
        value_in = 32'h11111111;
        wr(2'd0, 32'h00FF0001);
        k = 0;
        step_to(5);
        chk("snap d2 seg", {24'd0, seg}, 32'hF9);
        chk("snap d2 dig", {24'd0, dig}, 32'hFB);
        value_in = 32'h22222222;
        step_to(7);
        chk("snap d3 seg", {24'd0, seg}, 32'hF9);
        step_to(15);
        chk("snap d7 seg", {24'd0, seg}, 32'hF9);
        chk("snap d7 dig", {24'd0, dig}, 32'h7F);
        step_to(16);
        chk("snap fd", {31'd0, frame_done}, 32'd1);
        step_to(17);
        chk("snap next seg", {24'd0, seg}, 32'hA4);
        chk("snap next dig", {24'd0, dig}, 32'hFE);
        // EN cleared during DRIVE of digit 4, DIV=3, then re-enable
        wr(2'd0, 32'd0);
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h00FF0001);
        k = 0;
        step_to(17);
        rd(2'd2, r); chk("d4 status", r, 32'h204);
        chk("d4 dig", {24'd0, dig}, 32'hEF);
        wr(2'd0, 32'h00FF0000);
        rd(2'd2, r); chk("off status", r, 32'd0);
        chk("off dig", {24'd0, dig}, 32'hFF);
        chk("off seg", {24'd0, seg}, 32'hFF);
        wr(2'd0, 32'h00FF0001);
        rd(2'd2, r); chk("reen status", r, 32'h100);
        chk("reen dig", {24'd0, dig}, 32'hFF);
        @(negedge clk);
        rd(2'd2, r); chk("reen d0 status", r, 32'h200);
        chk("reen d0 dig", {24'd0, dig}, 32'hFE);
        chk("reen d0 seg", {24'd0, seg}, 32'hA4);
        // DIV=0 acts as DIV=1; FRAMES write coinciding with wrap clears
        wr(2'd0, 32'd0);
        wr(2'd3, 32'd0);
        wr(2'd1, 32'd0);
        rd(2'd1, r); chk("DIV0 rb", r, 32'd0);
        rd(2'd3, r); chk("FRAMES clr", r, 32'd0);
        wr(2'd0, 32'h00FF0001);
        k = 0;
        step_to(1);
        chk("div0 d0 dig", {24'd0, dig}, 32'hFE);
        step_to(2);
        chk("div0 blank dig", {24'd0, dig}, 32'hFF);
        step_to(15);
        chk("div0 d7 dig", {24'd0, dig}, 32'h7F);
        chk("div0 fd k15", {31'd0, frame_done}, 32'd0);
        step_to(16);
        chk("div0 fd k16", {31'd0, frame_done}, 32'd1);
        rd(2'd3, r); chk("FRAMES=1", r, 32'd1);
        step_to(31);
        wr(2'd3, 32'hDEAD);
        chk("wrap fd", {31'd0, frame_done}, 32'd1);
        rd(2'd3, r); chk("FRAMES clr wins", r, 32'd0);
        step_to(48);
        rd(2'd3, r); chk("FRAMES after", r, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
